// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the E/D pipeline stages and the
// iterative multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic [1:0]       MulDivOpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             MulDivD;
  logic             HiLoReadD;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             StallMD;
  logic             DoneM;

  modport master (
    output StartE, MulDivOpE, SrcAE, SrcBE, MulDivD, HiLoReadD,
    input  Hi, Lo, Busy, StallMD, DoneM
  );

  modport slave (
    input  StartE, MulDivOpE, SrcAE, SrcBE, MulDivD, HiLoReadD,
    output Hi, Lo, Busy, StallMD, DoneM
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU engine with HI/LO registers. Runs on
// magnitudes one bit per cycle, then fixes up signs in a final FIX cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } stateT;

  function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] x);
    return (~x) + (2*WIDTH)'(1);
  endfunction

  stateT            stateR, nextState;
  logic [CNTW-1:0]  countR;
  logic [WIDTH:0]   accR;        // product high half, or partial remainder
  logic [WIDTH-1:0] lowR;        // multiplier, or dividend/quotient
  logic [WIDTH-1:0] opBR;        // multiplicand, or divisor
  logic             signAR, signBR, divOpR, doneR;
  logic [WIDTH-1:0] hiR, loR;

  logic             signedOp, divZero, lastIter, remGe;
  logic [WIDTH-1:0] magA, magB, quoFix, remFix;
  logic [WIDTH:0]   mulSum, remShift, remDiff;
  logic [2*WIDTH-1:0] product, productFix;

  // Operand magnitudes, per-iteration arithmetic and final sign fix-up
  always_comb begin
    signedOp   = ~bus.MulDivOpE[0];
    magA       = (signedOp & bus.SrcAE[WIDTH-1]) ? negW(bus.SrcAE) : bus.SrcAE;
    magB       = (signedOp & bus.SrcBE[WIDTH-1]) ? negW(bus.SrcBE) : bus.SrcBE;
    divZero    = bus.MulDivOpE[1] & (bus.SrcBE == {WIDTH{1'b0}});
    lastIter   = (countR == CNTW'(WIDTH - 1));
    mulSum     = accR + (lowR[0] ? {1'b0, opBR} : {(WIDTH+1){1'b0}});
    remShift   = {accR[WIDTH-1:0], lowR[WIDTH-1]};
    remDiff    = remShift - {1'b0, opBR};
    remGe      = (remShift >= {1'b0, opBR});
    product    = {accR[WIDTH-1:0], lowR};
    productFix = (signAR ^ signBR) ? neg2W(product) : product;
    quoFix     = (signAR ^ signBR) ? negW(lowR) : lowR;
    remFix     = signAR ? negW(accR[WIDTH-1:0]) : accR[WIDTH-1:0];
  end

  // Next-state logic
  always_comb begin
    nextState = stateR;
    case (stateR)
      IDLE: begin
        if (bus.StartE) begin
          if (bus.MulDivOpE[1]) begin
            nextState = divZero ? IDLE : DIV;
          end else begin
            nextState = MUL;
          end
        end else begin
          nextState = IDLE;
        end
      end
      MUL:     nextState = lastIter ? FIX : MUL;
      DIV:     nextState = lastIter ? FIX : DIV;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR <= IDLE;
    end else begin
      stateR <= nextState;
    end
  end

  // Datapath, HI/LO and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      countR <= {CNTW{1'b0}};
      accR   <= {(WIDTH+1){1'b0}};
      lowR   <= {WIDTH{1'b0}};
      opBR   <= {WIDTH{1'b0}};
      signAR <= 1'b0;
      signBR <= 1'b0;
      divOpR <= 1'b0;
      hiR    <= {WIDTH{1'b0}};
      loR    <= {WIDTH{1'b0}};
      doneR  <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (stateR)
        IDLE: begin
          if (bus.StartE) begin
            countR <= {CNTW{1'b0}};
            accR   <= {(WIDTH+1){1'b0}};
            signAR <= signedOp & bus.SrcAE[WIDTH-1];
            signBR <= signedOp & bus.SrcBE[WIDTH-1];
            divOpR <= bus.MulDivOpE[1];
            lowR   <= bus.MulDivOpE[1] ? magA : magB;
            opBR   <= bus.MulDivOpE[1] ? magB : magA;
            // Divide by zero finishes immediately with a defined result
            if (divZero) begin
              loR   <= {WIDTH{1'b1}};
              hiR   <= bus.SrcAE;
              doneR <= 1'b1;
            end
          end
        end
        MUL: begin
          accR   <= {1'b0, mulSum[WIDTH:1]};
          lowR   <= {mulSum[0], lowR[WIDTH-1:1]};
          countR <= countR + CNTW'(1);
        end
        DIV: begin
          accR   <= remGe ? remDiff : remShift;
          lowR   <= {lowR[WIDTH-2:0], remGe};
          countR <= countR + CNTW'(1);
        end
        FIX: begin
          if (divOpR) begin
            loR <= quoFix;
            hiR <= remFix;
          end else begin
            {hiR, loR} <= productFix;
          end
          doneR <= 1'b1;
        end
        default: doneR <= 1'b0;
      endcase
    end
  end

  assign bus.Hi      = hiR;
  assign bus.Lo      = loR;
  assign bus.DoneM   = doneR;
  assign bus.Busy    = (stateR != IDLE);
  assign bus.StallMD = bus.Busy & (bus.MulDivD | bus.HiLoReadD);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed operations push expected
// {Hi,Lo}; a monitor pops and compares on every DoneM pulse.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(32)) bus();

  muldiv_sequencer #(.WIDTH(32), .CNTW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] expQ[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && bus.DoneM) begin
      if (expQ.size() == 0) begin
        check("unexpected DoneM", 64'd1, 64'd0);
      end else begin
        check("HiLo", {bus.Hi, bus.Lo}, expQ.pop_front());
      end
    end
  end

  task automatic doOp(input string name, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp, input int expBusy,
                      input logic holdRd, input logic holdMd, input logic poke);
    int n = 0;
    int s = 0;
    @(negedge clk);
    bus.StartE    = 1'b1;
    bus.MulDivOpE = op;
    bus.SrcAE     = a;
    bus.SrcBE     = b;
    bus.HiLoReadD = holdRd;
    bus.MulDivD   = holdMd;
    expQ.push_back(exp);
    @(negedge clk);
    bus.StartE = 1'b0;
    while (bus.Busy && n < 100) begin
      n++;
      if (bus.StallMD) s++;
      if (poke && n == 5) begin
        bus.StartE    = 1'b1;
        bus.MulDivOpE = 2'b11;
        bus.SrcAE     = 32'h0000_0055;
        bus.SrcBE     = 32'h0000_0000;
      end else begin
        bus.StartE = 1'b0;
      end
      @(negedge clk);
    end
    bus.StartE = 1'b0;
    check({name, " busy cycles"}, 64'(n), 64'(expBusy));
    check({name, " stall cycles"}, 64'(s), (holdRd | holdMd) ? 64'(expBusy) : 64'd0);
    check({name, " stall released"}, 64'(bus.StallMD), 64'd0);
    bus.HiLoReadD = 1'b0;
    bus.MulDivD   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.StartE    = 1'b0;
    bus.MulDivOpE = 2'b00;
    bus.SrcAE     = 32'h0;
    bus.SrcBE     = 32'h0;
    bus.MulDivD   = 1'b1;
    bus.HiLoReadD = 1'b1;
    repeat (2) @(negedge clk);
    check("reset Busy",    64'(bus.Busy),    64'd0);
    check("reset StallMD", 64'(bus.StallMD), 64'd0);
    check("reset DoneM",   64'(bus.DoneM),   64'd0);
    check("reset HiLo",    {bus.Hi, bus.Lo}, 64'd0);
    reset         = 1'b0;
    bus.MulDivD   = 1'b0;
    bus.HiLoReadD = 1'b0;

    doOp("MULT -3x7",    2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 33, 1'b1, 1'b0, 1'b0);
    doOp("MULTU max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 1'b0, 1'b1, 1'b0);
    doOp("MULT big",     2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 33, 1'b0, 1'b0, 1'b0);
    doOp("DIV -7/2",     2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0, 1'b0, 1'b0);
    doOp("DIVU 7/2",     2'b11, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003, 33, 1'b0, 1'b0, 1'b1);
    doOp("DIV 7/-2",     2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, 1'b0, 1'b0, 1'b0);
    doOp("DIV min/-1",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 1'b0, 1'b0, 1'b0);
    doOp("DIVU 100/0",   2'b11, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF, 0,  1'b1, 1'b0, 1'b0);
    doOp("DIV -7/0",     2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF, 0,  1'b0, 1'b0, 1'b0);

    // Abandon a divide partway through with an asynchronous reset
    @(negedge clk);
    bus.StartE    = 1'b1;
    bus.MulDivOpE = 2'b10;
    bus.SrcAE     = 32'h0000_03E8;
    bus.SrcBE     = 32'h0000_0003;
    @(negedge clk);
    bus.StartE = 1'b0;
    repeat (9) @(negedge clk);
    check("mid-op Busy", 64'(bus.Busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort Busy",  64'(bus.Busy),  64'd0);
    check("abort DoneM", 64'(bus.DoneM), 64'd0);
    check("abort HiLo",  {bus.Hi, bus.Lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    doOp("MULTU 2x3",    2'b01, 32'h0000_0002, 32'h0000_0003, 64'h0000_0000_0000_0006, 33, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
